dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Target (responder) side of the data-memory load/store interface that the pipeline's MEM stage initiates.
- Accepts one request at a time over a valid/ready handshake, waits LATENCY cycles, performs the access, then returns a response over a second valid/ready handshake.
- Byte-addressed, little-endian storage.
- Supports RV64 load/store sizes: byte, half, word and double, with signed or unsigned load extension.

Parameters:
- DEPTH_BYTES, 512, storage size in bytes; must be a multiple of 8.
- LATENCY, 2, number of wait cycles between request acceptance and response valid; legal range 0..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address (ALU result).
- req_wdata  input  64  store data; the low size bytes are used.
- req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (funct3[1:0]).
- req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0 (funct3[2]).
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  64  extended load data; 0 for stores and for errors.
- resp_err  output  1  access was misaligned or out of range.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Any in-flight request is dropped with no write performed.
  - Memory contents are not affected by reset.
- State IDLE: req_ready=1.
  - On req_valid&&req_ready, capture write, addr, wdata, size and unsigned.
  - Then go to BUSY with wait counter = LATENCY-1, or go straight to RESP when LATENCY==0.
- State BUSY: req_ready=0.
  - The counter decrements each cycle.
  - When the counter==0, perform the access and go to RESP.
- Access, done once per request at the BUSY->RESP transition (or at IDLE->RESP when LATENCY==0):
  - nbytes = 1<<size.
  - err = (addr mod nbytes != 0) || (addr+nbytes > DEPTH_BYTES); compute in 65 bits so no wrap near 2^64.
  - Store with no error: write bytes mem[addr+i] = wdata[8i+7:8i] for i < nbytes; resp_rdata=0.
  - Load with no error: assemble the little-endian bytes, then zero-extend or sign-extend from bit 8*nbytes-1. For size 3, unsigned has no effect.
  - Error: no memory change; resp_rdata=0, resp_err=1.
- State RESP: resp_valid=1 and req_ready=0.
  - resp_rdata and resp_err stay stable until resp_valid&&resp_ready.
  - On that handshake, go to IDLE; resp_valid drops the next cycle.
  - A new request can be accepted no earlier than the cycle after the response handshake, so the minimum request-to-request spacing is LATENCY+2 cycles.
- Only one request is outstanding at a time; req_valid is ignored outside IDLE.
- A response is held indefinitely while resp_ready==0; there is no timeout.
- A load issued after a store to the same address returns the stored data (program order, single port).

Optional Feature:
- Macro: DMEM_PERF_EN.
- When defined, three 32-bit output ports are added: load_count, store_count and err_count.
  - Each increments by 1 at the access point of the matching request; an error request counts only in err_count.
  - All three are reset to 0 by reset and wrap modulo 2^32.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store then load (LATENCY=2): store double addr=0x10, wdata=0x1122334455667788, then load size 3 at 0x10. Required: resp_valid 3 cycles after each request acceptance; the load returns 0x1122334455667788 with resp_err=0.
- Sign/zero extension: after the store above, load byte at 0x10 with unsigned=0 -> 0xFFFFFFFFFFFFFF88; with unsigned=1 -> 0x88; load half at 0x16 signed -> 0x0000000000001122.
- Misaligned and out of range:
  - Store word at 0x12 -> resp_err=1 and memory unchanged; a re-read of 0x10 still gives 0x1122334455667788.
  - Load double at DEPTH_BYTES-4 -> resp_err=1 with rdata=0.
  - Load byte at 0xFFFFFFFFFFFFFFFF -> resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles. Required: resp_valid, resp_rdata and resp_err are stable throughout and req_ready=0; a req_valid pulse in that window is not accepted; after the resp_ready handshake, req_ready=1 on the next cycle.
- Reset mid-operation: accept a store to 0x20 (wdata=0xAA), assert reset during BUSY. Required: IDLE, req_ready=1 and resp_valid=0 after reset; a subsequent load of 0x20 returns the prior contents, i.e. no write happened.
- LATENCY=0 build, with DMEM_PERF_EN defined: a request accepted at cycle n gives resp_valid at n+1. After 2 loads, 1 store and 1 misaligned load: load_count=2, store_count=1, err_count=1.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Load/store request and response bundle between the pipeline MEM stage
// (master, the initiator) and the data memory (slave, the responder).
//
// Request channel  : req_valid, req_ready, req_write, req_addr[63:0],
//                    req_wdata[63:0], req_size[1:0], req_unsigned
// Response channel : resp_valid, resp_ready, resp_rdata[63:0], resp_err
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Responder side of the data-memory load/store interface. Accepts one request
// at a time, waits LATENCY cycles, performs the byte-addressed little-endian
// access, then holds the response until the initiator takes it.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-low
//   bus    - dmem_responder_if.slave (request and response handshakes)
//   load_count, store_count, err_count - 32-bit access counters, present only
//            when the DMEM_PERF_EN macro is defined
//
// Parameters:
//   DEPTH_BYTES - storage size in bytes (multiple of 8)
//   LATENCY     - wait cycles between acceptance and response (0..15)
module dmem_responder #(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count,
  output logic [31:0]       err_count
`endif
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        capture, access;

  logic        write_q, unsigned_q;
  logic [63:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [7:0]  mem [DEPTH_BYTES];

  // Operands of the access. With LATENCY==0 the access happens in the same
  // cycle the request is accepted, so the live bus fields are used directly.
  logic        a_write, a_unsigned;
  logic [63:0] a_addr, a_wdata;
  logic [1:0]  a_size;
  logic [7:0]  byte_en;
  logic [2:0]  align_mask;
  logic [64:0] a_end;
  logic        a_err;
  logic [AW-1:0] a_idx;
  logic [63:0] raw, load_val;
  logic        sx;

  always_comb begin
    if (state == IDLE) begin
      a_write    = bus.req_write;
      a_addr     = bus.req_addr;
      a_wdata    = bus.req_wdata;
      a_size     = bus.req_size;
      a_unsigned = bus.req_unsigned;
    end else begin
      a_write    = write_q;
      a_addr     = addr_q;
      a_wdata    = wdata_q;
      a_size     = size_q;
      a_unsigned = unsigned_q;
    end
  end

  // Error check is done in 65 bits so an address near 2^64 cannot wrap into
  // range; the read path assembles bytes and then extends from the top bit.
  always_comb begin
    byte_en    = 8'h01;
    align_mask = 3'b000;
    unique case (a_size)
      2'd0: begin byte_en = 8'h01; align_mask = 3'b000; end
      2'd1: begin byte_en = 8'h03; align_mask = 3'b001; end
      2'd2: begin byte_en = 8'h0F; align_mask = 3'b011; end
      default: begin byte_en = 8'hFF; align_mask = 3'b111; end
    endcase
    a_end = {1'b0, a_addr} + (65'd1 << a_size);
    a_err = (|(a_addr[2:0] & align_mask)) || (a_end > 65'(DEPTH_BYTES));
    a_idx = a_addr[AW-1:0];
    raw   = '0;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) raw[8*i +: 8] = mem[a_idx + AW'(i)];
    end
    sx = ~a_unsigned;
    unique case (a_size)
      2'd0: load_val = {{56{sx & raw[7]}},  raw[7:0]};
      2'd1: load_val = {{48{sx & raw[15]}}, raw[15:0]};
      2'd2: load_val = {{32{sx & raw[31]}}, raw[31:0]};
      default: load_val = raw;
    endcase
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    capture        = 1'b0;
    access         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            access     = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // State register and response latch; response data is captured once at the
  // access point and held stable for the whole RESP phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (access) begin
        err_q   <= a_err;
        rdata_q <= (a_err || a_write) ? 64'd0 : load_val;
      end
    end
  end

  // Request capture needs no reset: the fields are only used after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      write_q    <= bus.req_write;
      addr_q     <= bus.req_addr;
      wdata_q    <= bus.req_wdata;
      size_q     <= bus.req_size;
      unsigned_q <= bus.req_unsigned;
    end
  end

  // Storage is untouched by reset; a reset edge also suppresses any write.
  always_ff @(posedge clk) begin
    if (reset && access && a_write && !a_err) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en[i]) mem[a_idx + AW'(i)] <= a_wdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_PERF_EN
  // Error requests count only as errors, never as loads or stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      load_count  <= '0;
      store_count <= '0;
      err_count   <= '0;
    end else if (access) begin
      if (a_err)        err_count   <= err_count + 32'd1;
      else if (a_write) store_count <= store_count + 32'd1;
      else              load_count  <= load_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed bench for dmem_responder: one LATENCY=2 instance for the main
// scenarios and one LATENCY=0 instance for the zero-wait path. Counter checks
// are included when DMEM_PERF_EN is defined.
module tb_dmem_responder;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dmem_responder_if bus();
  dmem_responder_if bus0();

`ifdef DMEM_PERF_EN
  logic [31:0] lc, sc, ec, lc0, sc0, ec0;
`endif

  dmem_responder #(.DEPTH_BYTES(512), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef DMEM_PERF_EN
    , .load_count(lc), .store_count(sc), .err_count(ec)
`endif
  );

  dmem_responder #(.DEPTH_BYTES(512), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
`ifdef DMEM_PERF_EN
    , .load_count(lc0), .store_count(sc0), .err_count(ec0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on the LATENCY=2 instance and wait for its response.
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [63:0] rdata, output logic err, output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_size = size; bus.req_unsigned = uns;
    bus.resp_ready = 1'b1;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
      if (bus.resp_valid) break;
    end
    n_tests++;
    if (!bus.resp_valid) begin
      n_fail++; lat = -1;
      $display("[TB] FAIL response timeout addr=%h: got no resp_valid, expected resp_valid=1", addr);
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
  endtask

  // Same transaction on the LATENCY=0 instance.
  task automatic do_req0(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic [63:0] rdata, output logic err, output int lat);
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = wr; bus0.req_addr = addr;
    bus0.req_wdata = wdata; bus0.req_size = size; bus0.req_unsigned = uns;
    bus0.resp_ready = 1'b1;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus0.req_valid = 1'b0;
      lat++;
      if (bus0.resp_valid) break;
    end
    n_tests++;
    if (!bus0.resp_valid) begin
      n_fail++; lat = -1;
      $display("[TB] FAIL response timeout (lat0) addr=%h: got no resp_valid, expected resp_valid=1", addr);
    end
    rdata = bus0.resp_rdata;
    err   = bus0.resp_err;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset req_ready: got %b expected 1", bus.req_ready); end
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset resp_valid: got %b expected 0", bus.resp_valid); end
    n_tests++; if (bus.resp_rdata !== 64'd0) begin n_fail++; $display("[TB] FAIL reset resp_rdata: got %h expected 0", bus.resp_rdata); end
    n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset resp_err: got %b expected 0", bus.resp_err); end
    n_tests++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset lat0 req_ready: got %b expected 1", bus0.req_ready); end
`ifdef DMEM_PERF_EN
    n_tests++; if ({lc0, sc0, ec0} !== 96'd0) begin n_fail++; $display("[TB] FAIL reset counters: got %0d/%0d/%0d expected 0/0/0", lc0, sc0, ec0); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL store latency: got %0d expected 3", lat); end
    n_tests++; if (er !== 1'b0 || rd !== 64'd0) begin n_fail++; $display("[TB] FAIL store resp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    do_req(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL load latency: got %0d expected 3", lat); end
    n_tests++; if (rd !== 64'h1122334455667788 || er !== 1'b0) begin n_fail++; $display("[TB] FAIL load double: got %h err=%b expected 1122334455667788 err=0", rd, er); end
  endtask

  task automatic test_extension();
    logic [63:0] rd; logic er; int lat;
    do_req(1'b0, 64'h10, 64'd0, 2'd0, 1'b0, rd, er, lat);
    n_tests++; if (rd !== 64'hFFFFFFFFFFFFFF88) begin n_fail++; $display("[TB] FAIL lb signed: got %h expected ffffffffffffff88", rd); end
    do_req(1'b0, 64'h10, 64'd0, 2'd0, 1'b1, rd, er, lat);
    n_tests++; if (rd !== 64'h88) begin n_fail++; $display("[TB] FAIL lbu: got %h expected 88", rd); end
    do_req(1'b0, 64'h16, 64'd0, 2'd1, 1'b0, rd, er, lat);
    n_tests++; if (rd !== 64'h1122) begin n_fail++; $display("[TB] FAIL lh 0x16: got %h expected 1122", rd); end
    do_req(1'b0, 64'h14, 64'd0, 2'd2, 1'b1, rd, er, lat);
    n_tests++; if (rd !== 64'h11223344) begin n_fail++; $display("[TB] FAIL lwu 0x14: got %h expected 11223344", rd); end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h12, 64'hDEADBEEF, 2'd2, 1'b0, rd, er, lat);
    n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("[TB] FAIL misaligned sw: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    do_req(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("[TB] FAIL reread after err: got %h expected 1122334455667788", rd); end
    do_req(1'b0, 64'd508, 64'd0, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("[TB] FAIL ld at depth-4: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    do_req(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 2'd0, 1'b0, rd, er, lat);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("[TB] FAIL lb at 2^64-1: got err=%b expected 1", er); end
    do_req(1'b0, 64'd504, 64'd0, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL ld at depth-8: got err=%b expected 0", er); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er; int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h10;
    bus.req_wdata = 64'd0; bus.req_size = 2'd3; bus.req_unsigned = 1'b0;
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid) break;
    end
    n_tests++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL backpressure start: got resp_valid=%b expected 1", bus.resp_valid); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_err !== 1'b0 ||
          bus.resp_rdata !== 64'h1122334455667788) begin
        n_fail++;
        $display("[TB] FAIL backpressure hold %0d: got valid=%b ready=%b err=%b rdata=%h expected 1/0/0/1122334455667788",
                 k, bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata);
      end
      if (k == 1) begin
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 64'h10;
        bus.req_wdata = 64'd0; bus.req_size = 2'd3;
      end
      if (k == 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL after handshake: got valid=%b ready=%b expected 0/1", bus.resp_valid, bus.req_ready); end
    do_req(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("[TB] FAIL ignored pulse: got %h expected 1122334455667788", rd); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h20, 64'h0123456789ABCDEF, 2'd3, 1'b0, rd, er, lat);
    do_req(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, rd, er, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 64'h20;
    bus.req_wdata = 64'hAA; bus.req_size = 2'd3; bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL busy req_ready: got %b expected 0", bus.req_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 64'd0) begin
      n_fail++;
      $display("[TB] FAIL mid reset: got ready=%b valid=%b rdata=%h expected 1/0/0", bus.req_ready, bus.resp_valid, bus.resp_rdata);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dropped request responded: got valid=%b expected 0", bus.resp_valid); end
    do_req(1'b0, 64'h20, 64'd0, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (rd !== 64'h0123456789ABCDEF) begin n_fail++; $display("[TB] FAIL no write on reset: got %h expected 0123456789abcdef", rd); end
  endtask

  task automatic test_latency0();
    logic [63:0] rd; logic er; int lat;
    do_req0(1'b1, 64'h40, 64'h8000000000000001, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (lat !== 1 || er !== 1'b0) begin n_fail++; $display("[TB] FAIL lat0 store: got lat=%0d err=%b expected 1/0", lat, er); end
    do_req0(1'b0, 64'h40, 64'd0, 2'd3, 1'b0, rd, er, lat);
    n_tests++; if (lat !== 1 || rd !== 64'h8000000000000001) begin n_fail++; $display("[TB] FAIL lat0 ld: got lat=%0d rdata=%h expected 1/8000000000000001", lat, rd); end
    do_req0(1'b0, 64'h47, 64'd0, 2'd0, 1'b0, rd, er, lat);
    n_tests++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin n_fail++; $display("[TB] FAIL lat0 lb: got %h expected ffffffffffffff80", rd); end
    do_req0(1'b0, 64'h41, 64'd0, 2'd1, 1'b0, rd, er, lat);
    n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("[TB] FAIL lat0 misaligned lh: got err=%b rdata=%h expected 1/0", er, rd); end
`ifdef DMEM_PERF_EN
    @(negedge clk);
    n_tests++; if (lc0 !== 32'd2 || sc0 !== 32'd1 || ec0 !== 32'd1) begin n_fail++; $display("[TB] FAIL perf counters: got %0d/%0d/%0d expected 2/1/1", lc0, sc0, ec0); end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = 2'd0; bus.req_unsigned = 1'b0; bus.resp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.req_size = 2'd0; bus0.req_unsigned = 1'b0; bus0.resp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_extension();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_latency0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
